fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the CPU datapath, directly downstream of the `pc` register. It presents the current PC to instruction memory, waits on a request/ready handshake, and computes `next_pc`, which is fed back into `pc.in`. It captures fetched instructions into the IF/ID pipeline register and handles decode stalls with a one-entry skid buffer. It also handles branch/jump redirects and reset-vector loading.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: address driven on `next_pc` while reset is asserted.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pc`  in  32: current PC from the `pc` register output.
- `next_pc`  out  32: combinational; drives `pc.in`.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address; always equals `pc`.
- `imem_ready`  in  1: `imem_rdata` is valid for `imem_addr` this cycle.
- `imem_rdata`  in  32: instruction word.
- `stall`  in  1: decode cannot accept a new IF/ID entry this cycle.
- `redirect`  in  1: a taken branch or jump; flush and refetch.
- `redirect_target`  in  32: new PC when `redirect`=1.
- `ifid_valid`  out  1: IF/ID entry holds a real instruction. Registered.
- `ifid_instr`  out  32: IF/ID instruction. Registered.
- `ifid_pc4`  out  32: IF/ID PC+4 of that instruction. Registered.

## Operation
- FSM states are FETCH and HOLD. Reset state is FETCH.
- Priority order: `rst`, then `redirect`, then normal operation.
- **`rst`=1:**
  - `imem_req`=0 and `next_pc`=RESET_VECTOR.
  - On the next edge: `ifid_valid`=0, `ifid_instr`=0, `ifid_pc4`=0, skid cleared, state FETCH.
  - The same rules apply when reset arrives mid-operation in any state.
- **`redirect`=1 (any state):**
  - `next_pc`=`redirect_target`.
  - `imem_ready` is ignored this cycle.
  - On the edge: `ifid_valid`=0, skid discarded, state FETCH.
  - Redirect overrides a simultaneous `stall`.
- **FETCH:** `imem_req`=1.
  - `imem_ready`=1, `stall`=0: IF/ID loads {1, `imem_rdata`, `pc`+4}; `next_pc`=`pc`+4; state stays FETCH.
  - `imem_ready`=1, `stall`=1: the word is captured in the skid; `next_pc`=`pc`; IF/ID holds; state goes to HOLD.
  - `imem_ready`=0, `stall`=0: `next_pc`=`pc`; IF/ID loads a bubble (`ifid_valid`=0; instr/pc4 hold their values).
  - `imem_ready`=0, `stall`=1: `next_pc`=`pc`; IF/ID holds.
- **HOLD:** `imem_req`=0 and `next_pc`=`pc`.
  - `stall`=1: IF/ID holds and the state stays HOLD.
  - `stall`=0: IF/ID loads {1, skid, `pc`+4}; `next_pc`=`pc`+4; state goes to FETCH.
- PC+4 is unsigned 32-bit modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Each instruction is delivered to IF/ID exactly once, in order. None are dropped, except those flushed by a redirect.

## Timing
- `next_pc`, `imem_req` and `imem_addr` are combinational from `pc`, state and inputs. Every other output is registered.
- Zero-wait memory (`imem_ready`=1 in the same cycle as the request) gives one instruction per clock: `ifid_*` updates on the edge that ends the fetch cycle, and `pc` advances on the same edge.
- N wait cycles give N bubbles on IF/ID when decode is not stalled.
- Redirect penalty: the redirect cycle plus at least one refetch cycle. The first target instruction appears in IF/ID no earlier than 2 edges after the redirect cycle.
- Stall released in HOLD: the buffered instruction appears on the next edge and the fetch of `pc`+4 starts the cycle after.

## Structure
- Shared header `constant_values.h` holds:
  - `WORD_ZERO` (already present);
  - new `WORD_FOUR`;
  - state encodings `FETCH_ST` and `HOLD_ST`;
  - `NOP_INSTR` (32'h0).
- One sub-module, `if_id_reg`:
  - ports `clk`, `rst`, `load`, `bubble`, `valid_in`, `instr_in`, `pc4_in`, plus the three outputs;
  - `rst`/flush clears the register;
  - `load` writes all fields;
  - `bubble` clears only `valid`;
  - otherwise the register holds.
- The FSM, skid register and next-PC mux live in `fetch_stage`. The existing `pc` module is instantiated only in the top-level datapath, not here.

## Test plan
- **Reset then zero-wait fetch:** after `rst` with RESET_VECTOR=32'h100, `imem_ready`=1 constantly → `pc` steps 100, 104, 108; `ifid_pc4` = 104, 108, 10C on consecutive edges; `ifid_valid`=1.
- **Wait states:** `imem_ready` low for 2 cycles at `pc`=32'h200 → `next_pc` holds 200; 2 bubbles (`ifid_valid`=0); then `ifid_instr`=`imem_rdata` and `ifid_pc4`=204.
- **Stall with skid:** ready with 32'hDEADBEEF at `pc`=32'h300 while `stall`=1 for 3 cycles → IF/ID holds the old entry and state is HOLD. One edge after stall drops: `ifid_instr`=DEADBEEF, `ifid_pc4`=304, `pc`=304.
- **Redirect during stall/HOLD:** `redirect`=1 with target 32'h4000 → next edge `ifid_valid`=0, `pc`=4000, skid discarded; the next IF/ID entry has `ifid_pc4`=4004.
- **Wrap:** `pc`=32'hFFFF_FFFC, ready → `next_pc`=0 and `ifid_pc4`=0.
- **Reset mid-HOLD:** `rst` asserted while in HOLD → all IF/ID fields 0, `imem_req`=0, `pc`=RESET_VECTOR on the next edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
    localparam logic [31:0] WORD_FOUR = 32'h0000_0004;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // FETCH: a request is outstanding. HOLD: a fetched word waits in the skid.
    typedef enum logic {
        FETCH_ST = 1'b0,
        HOLD_ST  = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset clears it, load writes every field,
// bubble clears only the valid flag, otherwise it holds.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    // Register update; load takes priority over bubble.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= WORD_ZERO;
        end else if (load) begin
            valid <= valid_in;
            instr <= instr_in;
            pc4   <= pc4_in;
        end else if (bubble) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: request/ready fetch from imem, one-entry skid for
// decode stalls, redirect flush and next-PC selection for the pc register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
);

    state_t      state;
    state_t      state_next;
    logic [31:0] skid;
    logic        skid_load;
    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] ifid_data;
    logic [31:0] pc4;

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to zero.
    assign pc4       = pc + WORD_FOUR;
    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_ST;
        end else begin
            state <= state_next;
        end
    end

    // Skid buffer: captures a word that arrived while decode was stalled.
    // NOTE: the skid is a single control-relevant register, so it is cleared
    // on reset to keep stale words from ever reaching IF/ID.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            skid <= NOP_INSTR;
        end else if (skid_load) begin
            skid <= imem_rdata;
        end
    end

    // Next-state, next-PC and IF/ID control; reset beats redirect beats normal flow.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        next_pc     = pc;
        imem_req    = 1'b0;
        skid_load   = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_data   = imem_rdata;

        if (rst) begin
            next_pc    = RESET_VECTOR;
            state_next = FETCH_ST;
        end else if (redirect) begin
            imem_req    = (state == FETCH_ST);
            next_pc     = redirect_target;
            ifid_bubble = 1'b1;
            state_next  = FETCH_ST;
        end else begin
            unique case (state)
                FETCH_ST: begin
                    imem_req = 1'b1;
                    if (imem_ready && !stall) begin
                        ifid_load = 1'b1;
                        next_pc   = pc4;
                    end else if (imem_ready && stall) begin
                        skid_load  = 1'b1;
                        state_next = HOLD_ST;
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD_ST: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_data  = skid;
                        next_pc    = pc4;
                        state_next = FETCH_ST;
                    end
                end
                default: state_next = FETCH_ST;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .valid_in (1'b1),
        .instr_in (ifid_data),
        .pc4_in   (pc4),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;

    int n_cmp = 0;
    int n_err = 0;

    // Model: architectural PC, IF/ID contents and an optional parked word.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_parked;
    logic [31:0] m_parked_word;

    fetch_stage #(.RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc4        (ifid_pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the external pc register.
    always @(posedge clk) pc <= next_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check combinational outputs, clock, check registers.
    task automatic step(input logic r, input logic rd, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] data, input logic st);
        logic [31:0] e_np;
        logic        e_req;
        logic [31:0] inc;
        rst = r; redirect = rd; redirect_target = tgt;
        imem_ready = rdy; imem_rdata = data; stall = st;
        inc = m_pc + 32'd4;
        e_req = 1'b0;
        e_np  = m_pc;
        if (r) begin
            e_np = RV;
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_parked = 1'b0;
        end else if (rd) begin
            e_np = tgt;
            m_valid = 1'b0; m_parked = 1'b0;
        end else if (!m_parked) begin
            e_req = 1'b1;
            if (rdy && !st) begin
                e_np = inc; m_valid = 1'b1; m_instr = data; m_pc4 = inc;
            end else if (rdy) begin
                m_parked = 1'b1; m_parked_word = data;
            end else if (!st) begin
                m_valid = 1'b0;
            end
        end else if (!st) begin
            e_np = inc; m_valid = 1'b1; m_instr = m_parked_word; m_pc4 = inc;
            m_parked = 1'b0;
        end
        #1;
        check("next_pc", next_pc, e_np);
        if (!rd) check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (!r) check("imem_addr", imem_addr, m_pc);
        m_pc = e_np;
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        check("ifid_instr", ifid_instr, m_instr);
        check("ifid_pc4", ifid_pc4, m_pc4);
    endtask

    initial begin
        logic [31:0] tgt;
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_parked = 1'b0; m_parked_word = 32'h0;

        // Reset, then zero-wait fetch from the reset vector.
        step(1, 0, 0, 1, $urandom, 0);
        step(1, 0, 0, 1, $urandom, 0);
        check("reset_pc", pc, 32'h100);
        check("reset_instr", ifid_instr, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom, 0);
        check("zero_wait_pc4", ifid_pc4, 32'h10C);
        check("zero_wait_valid", {31'b0, ifid_valid}, 32'h1);

        // Two wait states at 0x200.
        step(0, 1, 32'h200, 1, $urandom, 0);
        step(0, 0, 0, 0, $urandom, 0);
        check("wait_bubble", {31'b0, ifid_valid}, 32'h0);
        step(0, 0, 0, 0, $urandom, 0);
        step(0, 0, 0, 1, 32'h1234_5678, 0);
        check("wait_instr", ifid_instr, 32'h1234_5678);
        check("wait_pc4", ifid_pc4, 32'h204);

        // Stall with skid at 0x300.
        step(0, 1, 32'h300, 1, $urandom, 0);
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        step(0, 0, 0, 1, $urandom, 1);
        step(0, 0, 0, 0, $urandom, 1);
        step(0, 0, 0, 1, $urandom, 0);
        check("skid_instr", ifid_instr, 32'hDEAD_BEEF);
        check("skid_pc4", ifid_pc4, 32'h304);
        check("skid_pc", pc, 32'h304);

        // Redirect while in HOLD.
        step(0, 0, 0, 1, 32'hAAAA_0001, 1);
        step(0, 1, 32'h4000, 1, $urandom, 1);
        check("redir_pc", pc, 32'h4000);
        step(0, 0, 0, 1, $urandom, 0);
        check("redir_pc4", ifid_pc4, 32'h4004);

        // PC+4 wrap.
        step(0, 1, 32'hFFFF_FFFC, 1, $urandom, 0);
        step(0, 0, 0, 1, $urandom, 0);
        check("wrap_pc4", ifid_pc4, 32'h0);
        check("wrap_pc", pc, 32'h0);

        // Reset while in HOLD.
        step(0, 0, 0, 1, $urandom, 1);
        step(1, 0, 0, 1, $urandom, 1);
        check("hold_rst_valid", {31'b0, ifid_valid}, 32'h0);
        check("hold_rst_pc", pc, RV);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, tgt,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
